// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: consumer end of a show-ahead FIFO. It pops words and
// re-emits them on a valid/ready stream, framed into bursts of BURST_LEN beats
// with first/last markers. A partial burst is closed with last=1 after TIMEOUT
// idle cycles.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   fifo_data_out       FIFO head word (valid when fifo_data_out_vld=1)
//   fifo_data_out_vld   FIFO non-empty
//   fifo_data_pop       pop strobe, head word consumed this cycle (combinational)
//   out_data/out_valid/out_ready  output stream handshake
//   out_first/out_last  burst framing, qualified by out_valid
//   stat_bursts/stat_flushes  16-bit event counters (FIFO_BURST_RD_STATS_EN only)
//
// Optional feature macro: FIFO_BURST_RD_STATS_EN
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_data_out_vld,
  output logic                  fifo_data_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last
`ifdef FIFO_BURST_RD_STATS_EN
  ,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_flushes
`endif
);

  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [BEAT_W-1:0]     hold_beat_q, hold_beat_d;
  logic [BEAT_W-1:0]     next_beat_q, next_beat_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;

  logic hold_vld;
  logic out_load_ok;
  logic burst_end;
  logic timeout_hit;
  logic move;
  logic flush;
  logic pop;

`ifdef FIFO_BURST_RD_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [15:0] stat_flushes_q, stat_flushes_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_beat_q <= '0;
      next_beat_q <= '0;
      timer_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_beat_q <= hold_beat_d;
      next_beat_q <= next_beat_d;
      timer_q     <= timer_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state, pop and output-stage logic
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_beat_d = hold_beat_q;
    next_beat_d = next_beat_q;
    timer_d     = timer_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    hold_vld    = (state_q == ST_HOLD);
    out_load_ok = !out_valid_q || out_ready;
    burst_end   = (hold_beat_q == LAST_BEAT);
    timeout_hit = (timer_q == TIMER_MAX);
    move        = hold_vld && out_load_ok && (burst_end || fifo_data_out_vld || timeout_hit);
    flush       = move && timeout_hit;
    // A saturated timer commits the flush: no pop until the held word has moved.
    pop         = fifo_data_out_vld && !reset && (!hold_vld || (move && !timeout_hit));

    if (pop) begin
      hold_data_d = fifo_data_out;
      hold_beat_d = next_beat_q;
      next_beat_d = (next_beat_q == LAST_BEAT) ? '0 : next_beat_q + BEAT_W'(1);
    end else if (flush) begin
      next_beat_d = '0;
    end

    if (pop || !hold_vld) begin
      timer_d = '0;
    end else if (!fifo_data_out_vld && !timeout_hit) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    if (out_load_ok) begin
      if (move) begin
        out_data_d  = hold_data_q;
        out_valid_d = 1'b1;
        out_first_d = (hold_beat_q == '0);
        out_last_d  = burst_end || timeout_hit;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: if (pop) state_d = ST_HOLD;
      ST_HOLD: if (move && !pop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_data_pop = pop;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_first     = out_first_q;
  assign out_last      = out_last_q;

`ifdef FIFO_BURST_RD_STATS_EN
  // Burst and flush event counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bursts_q  <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_bursts_q  <= stat_bursts_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  always_comb begin
    stat_bursts_d  = stat_bursts_q;
    stat_flushes_d = stat_flushes_q;
    if (out_valid_q && out_ready && out_last_q) stat_bursts_d = stat_bursts_q + 16'd1;
    if (flush) stat_flushes_d = stat_flushes_q + 16'd1;
  end

  assign stat_bursts  = stat_bursts_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: self-checking bench for fifo_burst_reader with a
// behavioural show-ahead FIFO and a scoreboard of expected output beats.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_data_out_vld;
  logic          fifo_data_pop;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
`ifdef FIFO_BURST_RD_STATS_EN
  logic [15:0]   stat_bursts;
  logic [15:0]   stat_flushes;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_data_out    (fifo_data_out),
    .fifo_data_out_vld(fifo_data_out_vld),
    .fifo_data_pop    (fifo_data_pop),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_first        (out_first),
    .out_last         (out_last)
`ifdef FIFO_BURST_RD_STATS_EN
    ,
    .stat_bursts      (stat_bursts),
    .stat_flushes     (stat_flushes)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
    logic          flush;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fifo_q[$];
  int unsigned   beat_log[$];
  int unsigned   cyc;
  int unsigned   vectors;
  int unsigned   miscompares;
  int unsigned   exp_bursts;
  int unsigned   exp_flushes;
  logic          smp_pop;
  logic          smp_vld;
  logic [DW-1:0] smp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fifo_drive();
    fifo_data_out_vld = (fifo_q.size() != 0);
    fifo_data_out     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f, input logic l,
                      input logic fl, input logic expect_beat);
    exp_t e;
    fifo_q.push_back(d);
    if (expect_beat) begin
      e.data  = d;
      e.first = f;
      e.last  = l;
      e.flush = fl;
      sb.push_back(e);
    end
    fifo_drive();
  endtask

  // Sample one cycle at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    smp_pop  = fifo_data_pop;
    smp_vld  = out_valid;
    smp_data = out_data;
    if (out_valid && out_ready) begin
      beat_log.push_back(cyc);
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", 32'(out_data), 32'(e.data));
        chk("beat_first", 32'(out_first), 32'(e.first));
        chk("beat_last", 32'(out_last), 32'(e.last));
        if (e.last) exp_bursts++;
        if (e.flush) exp_flushes++;
      end
    end
    @(posedge clk);
    #1;
    if (smp_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    cyc++;
    fifo_drive();
  endtask

  task automatic drain(input string tag, input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && sb.size() != 0; i++) step();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned npops;
    logic        found;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    exp_bursts  = 0;
    exp_flushes = 0;
    reset       = 1'b1;
    out_ready   = 1'b1;
    fifo_drive();

    // Reset state
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_first", 32'(out_first), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_pop", 32'(fifo_data_pop), 32'd0);
    reset = 1'b0;

    // T1: eight preloaded words stream back-to-back as two full bursts
    beat_log.delete();
    for (int i = 0; i < 8; i++)
      push(DW'(8'h10 + i), (i % 4) == 0, (i % 4) == 3, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_pop", 32'(smp_pop), 32'd1);
    end
    drain("t1_drain", 40);
    chk("t1_beats", 32'(beat_log.size()), 32'd8);
    for (int i = 1; i < beat_log.size(); i++)
      chk("t1_rate", beat_log[i] - beat_log[i-1], 32'd1);

    // T2: partial burst flushed by timeout; A1 waits for TIMEOUT idle cycles
    // (pop at N+1, timer hits TIMEOUT at N+18, out at N+19 vs A0 at N+2)
    beat_log.delete();
    push(8'hA0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(8'hA1, 1'b0, 1'b1, 1'b1, 1'b1);
    drain("t2_drain", 60);
    chk("t2_beats", 32'(beat_log.size()), 32'd2);
    if (beat_log.size() == 2) chk("t2_gap", beat_log[1] - beat_log[0], 32'd17);
    push(8'hA2, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("t2_a2_drain", 60);

    // T3: backpressure allows exactly two pops and holds the output stable
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      push(DW'(8'h30 + i), (i % 4) == 0, (i % 4) == 3 || i == 5, i == 5, 1'b1);
    npops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      npops += 32'(smp_pop);
      if (smp_vld) chk("t3_hold_data", 32'(smp_data), 32'h30);
    end
    chk("t3_pops", npops, 32'd2);
    chk("t3_valid", 32'(smp_vld), 32'd1);
    beat_log.delete();
    out_ready = 1'b1;
    drain("t3_drain", 60);
    chk("t3_beats", 32'(beat_log.size()), 32'd6);
    for (int i = 1; i < 5 && i < beat_log.size(); i++)
      chk("t3_rate", beat_log[i] - beat_log[i-1], 32'd1);

    // T4: timeout saturates while blocked; a later word is not popped
    out_ready = 1'b0;
    push(8'hB0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(8'hB1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (25) step();
    push(8'hB5, 1'b1, 1'b1, 1'b1, 1'b1);
    npops = 0;
    repeat (5) begin
      step();
      npops += 32'(smp_pop);
    end
    chk("t4_no_pop", npops, 32'd0);
    chk("t4_hold_data", 32'(smp_data), 32'hB0);
    out_ready = 1'b1;
    drain("t4_drain", 60);

    // T5: reset mid-burst discards the held word and restarts framing
    push(8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(8'hC1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("t5_two_beats", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    push(8'hD0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("t5_pop_in_reset", 32'(smp_pop), 32'd0);
    chk("t5_valid_after_reset", 32'(out_valid), 32'd0);
`ifdef FIFO_BURST_RD_STATS_EN
    chk("t5_stat_bursts", 32'(stat_bursts), 32'd0);
    chk("t5_stat_flushes", 32'(stat_flushes), 32'd0);
    exp_bursts  = 0;
    exp_flushes = 0;
`endif
    reset = 1'b0;
    drain("t5_drain", 60);

    // T6: a word arriving on the timer==TIMEOUT cycle loses to the flush
    push(8'hE0, 1'b1, 1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = smp_pop;
    end
    chk("t6_pop_e0", 32'(found), 32'd1);
    repeat (16) step();
    push(8'hE1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("t6_flush_no_pop", 32'(smp_pop), 32'd0);
    step();
    chk("t6_pop_next", 32'(smp_pop), 32'd1);
    drain("t6_drain", 60);

`ifdef FIFO_BURST_RD_STATS_EN
    chk("stat_bursts", 32'(stat_bursts), exp_bursts);
    chk("stat_flushes", 32'(stat_flushes), exp_flushes);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
